// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : Execute-side request, writeback result and data-memory port
//            bundle for the load/store unit.
// Revision : 1.0
// ============================================================================
interface mem_access_unit_if #(
    parameter int XLEN = 32
);
    // Execute -> unit
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      mren;
    logic [1:0]      mwen;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    // Unit -> writeback
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rdata;
    logic            err;
    // Unit <-> data memory
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_we;
    logic [3:0]      mem_req_wmask;
    logic [XLEN-1:0] mem_req_wdata;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;

    modport master (
        input  in_valid, mren, mwen, addr, wdata, out_ready,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output in_ready, out_valid, rdata, err,
               mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata
    );

    modport slave (
        output in_valid, mren, mwen, addr, wdata, out_ready,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  in_ready, out_valid, rdata, err,
               mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Single-outstanding load/store stage with byte-lane stores and
//            sign-extended loads on a word-addressed data-memory port.
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    state_t          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            req_valid_q, req_valid_d;
    logic            req_we_q, req_we_d;
    logic [3:0]      req_wmask_q, req_wmask_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] req_wdata_q, req_wdata_d;
    logic [1:0]      ld_size_q, ld_size_d;
    logic [1:0]      ld_off_q, ld_off_d;

    logic            w_accept;
    logic [1:0]      w_size;
    logic            w_both;
    logic            w_misaligned;
    logic [3:0]      w_st_mask;
    logic [XLEN-1:0] w_st_data;
    logic [7:0]      w_ld_byte;
    logic [15:0]     w_ld_half;
    logic [XLEN-1:0] w_ld_data;

    assign bus.in_ready = (state_q == S_IDLE) && !rst;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // A conflicting mren/mwen pair errors out regardless of which size wins here.
    assign w_size       = (bus.mren != SZ_NONE) ? bus.mren : bus.mwen;
    assign w_both       = (bus.mren != SZ_NONE) && (bus.mwen != SZ_NONE);
    assign w_misaligned = ((w_size == SZ_HALF) && bus.addr[0]) ||
                          ((w_size == SZ_WORD) && (bus.addr[1:0] != 2'b00));

    always_comb begin
        w_st_mask = 4'b1111;
        w_st_data = bus.wdata;
        unique case (bus.mwen)
            SZ_BYTE: begin
                w_st_mask = 4'b0001 << bus.addr[1:0];
                w_st_data = {4{bus.wdata[7:0]}};
            end
            SZ_HALF: begin
                w_st_mask = 4'b0011 << bus.addr[1:0];
                w_st_data = {2{bus.wdata[15:0]}};
            end
            default: begin
                w_st_mask = 4'b1111;
                w_st_data = bus.wdata;
            end
        endcase
    end

    assign w_ld_byte = bus.mem_rsp_data[{ld_off_q, 3'b000} +: 8];
    assign w_ld_half = bus.mem_rsp_data[{ld_off_q[1], 4'b0000} +: 16];

    always_comb begin
        unique case (ld_size_q)
            SZ_BYTE: w_ld_data = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: w_ld_data = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
            default: w_ld_data = bus.mem_rsp_data;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_wmask_d = req_wmask_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        ld_size_d   = ld_size_q;
        ld_off_d    = ld_off_q;

        unique case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    ld_size_d = bus.mren;
                    ld_off_d  = bus.addr[1:0];
                    if (w_size == SZ_NONE) begin
                        state_d     = S_RESP;
                        out_valid_d = 1'b1;
                        rdata_d     = '0;
                        err_d       = 1'b0;
                    end else if (w_both || w_misaligned) begin
                        state_d     = S_RESP;
                        out_valid_d = 1'b1;
                        rdata_d     = '0;
                        err_d       = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                        req_we_d    = (bus.mwen != SZ_NONE);
                        req_addr_d  = {bus.addr[XLEN-1:2], 2'b00};
                        req_wmask_d = (bus.mwen != SZ_NONE) ? w_st_mask : 4'b0000;
                        req_wdata_d = w_st_data;
                    end
                end
            end
            S_REQ: begin
                // Stores complete at acceptance; only loads wait for a response.
                if (bus.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    if (req_we_q) begin
                        state_d     = S_RESP;
                        out_valid_d = 1'b1;
                        rdata_d     = '0;
                        err_d       = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_d     = S_RESP;
                    out_valid_d = 1'b1;
                    rdata_d     = w_ld_data;
                    err_d       = 1'b0;
                end
            end
            S_RESP: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_wmask_q <= 4'b0000;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            ld_size_q   <= SZ_NONE;
            ld_off_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_wmask_q <= req_wmask_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            ld_size_q   <= ld_size_d;
            ld_off_q    <= ld_off_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.rdata         = rdata_q;
    assign bus.err           = err_q;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_we    = req_we_q;
    assign bus.mem_req_wmask = req_wmask_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_req_wdata = req_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if #(.XLEN(32)) bus ();

    mem_access_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected behaviour of the operation currently in flight
    logic        exp_active = 1'b0;
    logic        exp_nomem  = 1'b1;
    logic        exp_err    = 1'b0;
    logic        exp_we     = 1'b0;
    logic [31:0] exp_addr   = '0;
    logic [3:0]  exp_wmask  = '0;
    logic [31:0] exp_wdata  = '0;
    logic [31:0] exp_rdata  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Model from the access rules: size in bytes, offset, lane membership.
    task automatic set_model(input logic [1:0] mr, input logic [1:0] mw,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] word);
        logic [1:0]  sz;
        int          n, o;
        logic [31:0] v, m;
        sz = (mr != 2'b00) ? mr : mw;
        n  = (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
        o  = int'(a[1:0]);
        exp_err   = ((mr != 2'b00) && (mw != 2'b00)) || ((sz != 2'b00) && ((o % n) != 0));
        exp_nomem = exp_err || (sz == 2'b00);
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_we    = (mw != 2'b00);
        exp_wmask = '0;
        exp_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (exp_we && i >= o && i < o + n) exp_wmask[i] = 1'b1;
            exp_wdata[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        exp_rdata = '0;
        if (!exp_nomem && !exp_we) begin
            v = word >> (8 * o);
            if (n < 4) begin
                m = (32'h1 << (8 * n)) - 32'h1;
                v = v & m;
                if (v[8*n-1]) v = v | ~m;
            end
            exp_rdata = v;
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req_valid) begin
                if (exp_nomem) begin
                    chk("unexpected_mem_req", 32'(bus.mem_req_valid), 32'h0);
                end else begin
                    chk("req_addr", bus.mem_req_addr, exp_addr);
                    chk("req_we", 32'(bus.mem_req_we), 32'(exp_we));
                    chk("req_wmask", 32'(bus.mem_req_wmask), 32'(exp_wmask));
                    if (exp_we) chk("req_wdata", bus.mem_req_wdata, exp_wdata);
                end
            end
            if (bus.out_valid) begin
                if (!exp_active) begin
                    chk("spurious_out_valid", 32'(bus.out_valid), 32'h0);
                end else begin
                    chk("out_rdata", bus.rdata, exp_rdata);
                    chk("out_err", 32'(bus.err), 32'(exp_err));
                end
            end
        end
    end

    task automatic do_op(input string name, input logic [1:0] mr, input logic [1:0] mw,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                         input int stall, input int hold, input int lit_lat,
                         input logic [31:0] lit_rdata, input logic lit_err, input logic lit_mem,
                         input logic [31:0] lit_addr, input logic [3:0] lit_wmask,
                         input logic [31:0] lit_wdata);
        int          lat, budget, stl;
        logic        rsp_pending, seen;
        logic [31:0] cap_addr, cap_wdata;
        logic [3:0]  cap_wmask;

        budget = 0;
        @(negedge clk);
        while (!bus.in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) begin
            chk({name, "_in_ready_wait"}, 32'(bus.in_ready), 32'h1);
            return;
        end

        set_model(mr, mw, a, wd, word);
        exp_active    = 1'b1;
        bus.out_ready = (hold == 0);
        bus.mren      = mr;
        bus.mwen      = mw;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;

        lat = 1; stl = stall; rsp_pending = 1'b0; seen = 1'b0;
        cap_addr = '0; cap_wdata = '0; cap_wmask = '0;
        while (lat < 40) begin
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = 32'hA5A5_5A5A;
            bus.mem_req_ready = 1'b0;
            if (rsp_pending) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = word;
                rsp_pending       = 1'b0;
            end
            if (bus.out_valid) break;
            if (bus.mem_req_valid) begin
                if (!seen) begin
                    cap_addr  = bus.mem_req_addr;
                    cap_wmask = bus.mem_req_wmask;
                    cap_wdata = bus.mem_req_wdata;
                end
                seen = 1'b1;
                if (stl > 0) begin
                    stl--;
                end else begin
                    bus.mem_req_ready = 1'b1;
                    rsp_pending       = !bus.mem_req_we;
                end
            end
            @(posedge clk);
            lat++;
        end

        chk({name, "_latency"}, 32'(lat), 32'(lit_lat));
        chk({name, "_rdata"}, bus.rdata, lit_rdata);
        chk({name, "_err"}, 32'(bus.err), 32'(lit_err));
        chk({name, "_mem_used"}, 32'(seen), 32'(lit_mem));
        if (lit_mem) begin
            chk({name, "_addr"}, cap_addr, lit_addr);
            chk({name, "_wmask"}, 32'(cap_wmask), 32'(lit_wmask));
            if (mw != 2'b00) chk({name, "_wdata"}, cap_wdata, lit_wdata);
        end

        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, "_hold_valid"}, 32'(bus.out_valid), 32'h1);
            chk({name, "_hold_rdata"}, bus.rdata, lit_rdata);
            chk({name, "_hold_in_ready"}, 32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_done_valid"}, 32'(bus.out_valid), 32'h0);
        chk({name, "_done_in_ready"}, 32'(bus.in_ready), 32'h1);
    endtask

    initial begin
        bus.in_valid      = 1'b0;
        bus.mren          = 2'b00;
        bus.mwen          = 2'b00;
        bus.addr          = '0;
        bus.wdata         = '0;
        bus.out_ready     = 1'b1;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_req_valid", 32'(bus.mem_req_valid), 32'h0);
        chk("reset_rdata", bus.rdata, 32'h0);
        chk("reset_err", 32'(bus.err), 32'h0);
        chk("reset_wmask", 32'(bus.mem_req_wmask), 32'h0);
        chk("reset_addr", bus.mem_req_addr, 32'h0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(bus.in_ready), 32'h1);

        //      name   mren   mwen   addr          wdata         memword       stl hld lat rdata         err  mem  addr          wmask    wdata
        do_op("LW",    2'b11, 2'b00, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 0, 0, 3, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h8000_0004, 4'b0000, 32'h0);
        do_op("LB",    2'b01, 2'b00, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 3, 32'hFFFF_FF80, 1'b0, 1'b1, 32'h0000_0100, 4'b0000, 32'h0);
        do_op("LH",    2'b10, 2'b00, 32'h0000_0102, 32'h0,        32'h7ABC_0000, 0, 0, 3, 32'h0000_7ABC, 1'b0, 1'b1, 32'h0000_0100, 4'b0000, 32'h0);
        do_op("LBpos", 2'b01, 2'b00, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 0, 3, 32'h0000_007F, 1'b0, 1'b1, 32'h0000_0100, 4'b0000, 32'h0);
        do_op("SW",    2'b00, 2'b11, 32'h0000_0010, 32'h1122_3344, 32'h0,        0, 0, 2, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 4'b1111, 32'h1122_3344);
        do_op("SB",    2'b00, 2'b01, 32'h0000_0012, 32'h0000_00AB, 32'h0,        0, 0, 2, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 4'b0100, 32'hABAB_ABAB);
        do_op("SH",    2'b00, 2'b10, 32'h0000_0012, 32'h0000_5566, 32'h0,        0, 0, 2, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 4'b1100, 32'h5566_5566);
        do_op("LWmis", 2'b11, 2'b00, 32'h0000_0006, 32'h0,        32'h0,        0, 0, 1, 32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0);
        do_op("LHmis", 2'b10, 2'b00, 32'h0000_0001, 32'h0,        32'h0,        0, 0, 1, 32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0);
        do_op("BOTH",  2'b11, 2'b11, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 1, 32'h0,        1'b1, 1'b0, 32'h0,        4'b0000, 32'h0);
        do_op("NOP",   2'b00, 2'b00, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0,        0, 0, 1, 32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 32'h0);
        do_op("SWstl", 2'b00, 2'b11, 32'h0000_0024, 32'hCAFE_F00D, 32'h0,        5, 0, 7, 32'h0,        1'b0, 1'b1, 32'h0000_0024, 4'b1111, 32'hCAFE_F00D);
        do_op("LHbp",  2'b10, 2'b00, 32'h0000_0002, 32'h0,        32'h8001_0000, 0, 3, 3, 32'hFFFF_8001, 1'b0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0);

        // Reset while a load waits for its response; the late response must be dropped.
        @(negedge clk);
        set_model(2'b11, 2'b00, 32'h0000_0020, 32'h0, 32'h0);
        exp_active    = 1'b0;
        bus.mren      = 2'b11;
        bus.mwen      = 2'b00;
        bus.addr      = 32'h0000_0020;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1 bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            chk("late_rsp_out_valid", 32'(bus.out_valid), 32'h0);
        end
        exp_active = 1'b1;

        do_op("NOPrec", 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h0, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the instruction decoder's micro-command output.
- Consumes the decoded memory-read and memory-write size fields (mren/mwen) plus the effective address and store data from execute.
- Drives a single-outstanding, valid/ready word-addressed data-memory port with byte lanes.
- Returns a sign-extended load result, or a completion token for stores and non-memory operations, to writeback.

Parameters:
- XLEN, 32, data and address width; the lane logic fixes this block at 32.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute presents a request.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- mren  in  2  load size: 00 none, 01 byte, 10 half, 11 word.
- mwen  in  2  store size, same encoding as mren.
- addr  in  XLEN  effective byte address.
- wdata  in  XLEN  store data, right-aligned.
- out_valid  out  1  result available to writeback.
- out_ready  in  1  writeback accepts the result.
- rdata  out  XLEN  sign-extended load data; 0 for stores, no-ops and errors.
- err  out  1  qualifies out_valid; misaligned access or illegal command.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  XLEN  word-aligned address, {addr[31:2],2'b00}.
- mem_req_we  out  1  1 = write request.
- mem_req_wmask  out  4  byte-lane write enables.
- mem_req_wdata  out  XLEN  lane-replicated store data.
- mem_rsp_valid  in  1  read data valid; single-cycle pulse.
- mem_rsp_data  in  XLEN  read word.

Behaviour:
- Reset: the rst cycle forces state IDLE.
- Registered outputs reset to 0: out_valid, rdata, err, mem_req_valid, mem_req_we, mem_req_wmask, mem_req_addr, mem_req_wdata.
- in_ready is 0 during the rst cycle and 1 on the first cycle after it.
- States are IDLE, REQ, WAIT, RESP.
- Accept: on in_valid && in_ready, latch mren, mwen, addr and wdata, then classify the request.
  - mren==0 && mwen==0 -> RESP, rdata=0, err=0, no memory traffic.
  - mren!=0 && mwen!=0 -> RESP, err=1, no memory traffic.
  - Misaligned -> RESP, err=1, no memory traffic. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise -> REQ.
- REQ: mem_req_valid=1. addr, we, wmask and wdata are held stable until mem_req_ready.
  - On the handshake, a write goes to RESP; a write completes at acceptance and no response is expected.
  - On the handshake, a read goes to WAIT.
  - mem_rsp_valid is ignored in REQ.
- Store lanes, with o=addr[1:0]:
  - Byte: wmask = 4'b0001<<o, wdata = {4{wdata[7:0]}}.
  - Half: wmask = 4'b0011<<o, wdata = {2{wdata[15:0]}}.
  - Word: wmask = 4'b1111, wdata unchanged.
  - For reads, mem_req_wmask = 0.
- WAIT: on mem_rsp_valid, extract the lane at byte offset o and sign-extend it, then go to RESP.
  - Byte: sext(data[8o+7:8o]).
  - Half: sext(data[8o+15:8o]).
  - Word: data unchanged.
  - Only signed loads exist; there is no zero-extension.
- RESP: out_valid=1, with rdata and err stable, until out_ready; then go to IDLE.
  - in_ready rises the following cycle; there is no same-cycle re-accept.
- Minimum latency, with request accepted at cycle T:
  - Store with ready=1: out_valid at T+2.
  - Load with ready=1 and the response one cycle after the handshake: out_valid at T+3.
  - No-op or error: out_valid at T+1.
- Reset mid-operation: any state returns to IDLE and mem_req_valid drops the next cycle. A late mem_rsp_valid arriving in IDLE is ignored and produces no out_valid.
- Backpressure: out_ready low holds RESP indefinitely, and no new request is accepted.
- Only one request is outstanding at a time; in_valid while in_ready=0 has no effect.

Test Plan:
- LW: addr=0x8000_0004, memory returns 0xDEAD_BEEF.
  - Required: mem_req_addr=0x8000_0004, we=0, rdata=0xDEAD_BEEF, err=0, out_valid at T+3.
- LB: addr=0x103, memory returns 0x80FF_1234.
  - Required: mem_req_addr=0x100, rdata=0xFFFF_FF80.
- LH: addr=0x102, memory returns 0x7ABC_0000.
  - Required: rdata=0x0000_7ABC.
- SW/SB/SH lanes:
  - SW at 0x10, wdata=0x1122_3344: wmask=1111, mem_wdata=0x1122_3344.
  - SB at 0x12, wdata=0xAB: wmask=0100, mem_wdata=0xABAB_ABAB.
  - SH at 0x12, wdata=0x5566: wmask=1100, mem_wdata=0x5566_5566.
- Errors, each giving out_valid at T+1, err=1 and no mem_req_valid:
  - LW at 0x6.
  - LH at 0x1.
  - mren=11 together with mwen=11.
- Stall and reset:
  - mem_req_ready low for 5 cycles: request fields stay stable throughout.
  - out_ready low for 3 cycles: rdata is held and in_ready=0 throughout.
  - rst asserted in WAIT, then mem_rsp_valid pulsed: state is IDLE and out_valid stays 0.
